// File: rtl/i2c_pkg.sv
//==============================================================================
// Package  : i2c_pkg
// Purpose  : Definitions shared by the I2C target register block and the I2C
//            master wrapper. It holds the target FSM state encoding, the STATUS
//            register bit positions, the STATUS byte address, the ctrl bus
//            response codes, and a helper that packs the STATUS byte.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package i2c_pkg;

    // Target-side bus FSM
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_BYTE  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } i2c_state_t;

    // STATUS register layout
    localparam int STAT_WR_DONE = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_PTR_LSB = 4;

    localparam logic [7:0] REG_STATUS  = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Builds the STATUS byte: ptr in [7:4], busy in bit 1, wr_done in bit 0
    function automatic logic [7:0] status_byte(input logic [3:0] ptr,
                                               input logic       busy,
                                               input logic       wr_done);
        logic [7:0] v;
        v                              = 8'h00;
        v[STAT_PTR_LSB +: 4]           = ptr;
        v[STAT_BUSY]                   = busy;
        v[STAT_WR_DONE]                = wr_done;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_target_regs_if.sv
//==============================================================================
// Interface : i2c_target_regs_if
// Purpose   : System-side ctrl register bus of the I2C target register file.
// Signals   : ctrl_address[7:0]   byte address (0x00-0x0F regs, 0x10 STATUS)
//             ctrl_read           read request
//             ctrl_write          write request
//             ctrl_writedata[31:0] write data, [7:0] used
//             ctrl_byteenable[3:0] only bit 0 is honoured
//             ctrl_readdata[31:0] read data, [7:0] valid
//             ctrl_response[1:0]  OKAY / SLVERR
//             ctrl_waitrequest    stall
// Modports  : master (bus initiator), slave (register block)
// Revision  : 1.0 - initial release
//==============================================================================
`default_nettype none

interface i2c_target_regs_if;

    logic [7:0]  ctrl_address;
    logic        ctrl_read;
    logic        ctrl_write;
    logic [31:0] ctrl_writedata;
    logic [3:0]  ctrl_byteenable;
    logic [31:0] ctrl_readdata;
    logic [1:0]  ctrl_response;
    logic        ctrl_waitrequest;

    modport master (
        output ctrl_address,
        output ctrl_read,
        output ctrl_write,
        output ctrl_writedata,
        output ctrl_byteenable,
        input  ctrl_readdata,
        input  ctrl_response,
        input  ctrl_waitrequest
    );

    modport slave (
        input  ctrl_address,
        input  ctrl_read,
        input  ctrl_write,
        input  ctrl_writedata,
        input  ctrl_byteenable,
        output ctrl_readdata,
        output ctrl_response,
        output ctrl_waitrequest
    );

endinterface

`default_nettype wire

// File: rtl/i2c_target_sync.sv
//==============================================================================
// Module   : i2c_target_sync
// Purpose  : Brings the asynchronous SCL/SDA pad inputs into the clk domain
//            and derives SCL edges plus START/STOP conditions.
// Ports    : clk, rst        system clock, synchronous active-high reset
//            scl_pad, sda_pad raw pad inputs
//            scl_rise        one-cycle pulse, SCL went 0->1
//            scl_fall        one-cycle pulse, SCL went 1->0
//            start           one-cycle pulse, SDA fell while SCL high
//            stop            one-cycle pulse, SDA rose while SCL high
//            sda             synchronised SDA level
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_target_sync (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic scl_pad,
    input  wire logic sda_pad,
    output logic      scl_rise,
    output logic      scl_fall,
    output logic      start,
    output logic      stop,
    output logic      sda
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_d;
    logic       r_sda_d;
    logic       w_scl;
    logic       w_sda;

    // Reset to the idle bus level so no spurious edge or START is reported
    // while the synchronisers refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_pad};
            r_sda_sync <= {r_sda_sync[0], sda_pad};
            r_scl_d    <= r_scl_sync[1];
            r_sda_d    <= r_sda_sync[1];
        end
    end

    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];

    assign scl_rise = w_scl & ~r_scl_d;
    assign scl_fall = ~w_scl & r_scl_d;
    // SCL must be high in both the current and previous sample, so an SDA
    // change that lines up with an SCL edge is never taken as START/STOP.
    assign start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign sda      = w_sda;

endmodule

`default_nettype wire

// File: rtl/i2c_target_regs.sv
//==============================================================================
// Module   : i2c_target_regs
// Purpose  : I2C target exposing a 16-byte register file at address DEV_ADDR.
//            The register file is also accessible from the system side through
//            the ctrl register bus. SCL is input-only (no clock stretching).
// Ports    : clk, rst   system clock, synchronous active-high reset
//            scl_i      SCL pad input
//            sda_i      SDA pad input
//            sda_o      SDA output value (always 0)
//            sda_t      SDA tristate, 1 = released, 0 = pull low
//            ctrl       ctrl register bus (slave modport)
//            irq        level interrupt, mirrors STATUS.wr_done
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h3C
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         scl_i,
    input  wire logic         sda_i,
    output logic              sda_o,
    output logic              sda_t,
    i2c_target_regs_if.slave  ctrl,
    output logic              irq
);

    //--------------------------------------------------------------------------
    // Pad synchronisation and bus event detection
    //--------------------------------------------------------------------------
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_sda;

    i2c_target_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_pad  (scl_i),
        .sda_pad  (sda_i),
        .scl_rise (w_scl_rise),
        .scl_fall (w_scl_fall),
        .start    (w_start),
        .stop     (w_stop),
        .sda      (w_sda)
    );

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    i2c_state_t r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_tx;
    logic [3:0] r_ptr;
    logic       r_first;
    logic       r_rw;
    logic       r_rd_more;
    logic       r_wrote;
    logic       r_wr_done;
    logic       r_sda_t;
    logic [7:0] r_regs [16];

    logic [7:0] w_byte;
    logic       w_busy;
    logic       w_ctrl_wr_reg;
    logic       w_ctrl_clr;

    // Byte completed by the bit arriving on this SCL rise
    assign w_byte = {r_shift[6:0], w_sda};
    assign w_busy = (r_state != ST_IDLE) && (r_state != ST_IGNORE);

    assign w_ctrl_wr_reg = ctrl.ctrl_write && ctrl.ctrl_byteenable[0] &&
                           (ctrl.ctrl_address[7:4] == 4'h0);
    assign w_ctrl_clr    = ctrl.ctrl_write && ctrl.ctrl_byteenable[0] &&
                           (ctrl.ctrl_address == REG_STATUS) &&
                           ctrl.ctrl_writedata[STAT_WR_DONE];

    //--------------------------------------------------------------------------
    // Bus FSM, register file and STATUS.wr_done.
    // The ctrl-side updates are written first so that a same-cycle I2C data
    // write or wr_done set, written later in the block, takes precedence.
    // In both ACK states r_sda_t doubles as the phase flag: still released at
    // an SCL fall means the ACK slot is starting, already low means it ends.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 8'h00;
            r_ptr     <= 4'h0;
            r_first   <= 1'b0;
            r_rw      <= 1'b0;
            r_rd_more <= 1'b0;
            r_wrote   <= 1'b0;
            r_wr_done <= 1'b0;
            r_sda_t   <= 1'b1;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            if (w_ctrl_wr_reg) begin
                r_regs[ctrl.ctrl_address[3:0]] <= ctrl.ctrl_writedata[7:0];
            end
            if (w_ctrl_clr) begin
                r_wr_done <= 1'b0;
            end

            if (w_start) begin
                // ptr is deliberately kept so a repeated START can read back
                // from the location set by the preceding write.
                r_state   <= ST_ADDR;
                r_bit_cnt <= 3'd0;
                r_rd_more <= 1'b0;
                r_sda_t   <= 1'b1;
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_rd_more <= 1'b0;
                r_sda_t   <= 1'b1;
                if (r_wrote) begin
                    r_wr_done <= 1'b1;
                    r_wrote   <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sda_t <= 1'b1;
                    end

                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_shift[6:0] == DEV_ADDR) begin
                                    r_state <= ST_ADDR_ACK;
                                    r_rw    <= w_sda;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (r_sda_t) begin
                                r_sda_t <= 1'b0;
                            end else if (!r_rw) begin
                                r_state   <= ST_WR_BYTE;
                                r_first   <= 1'b1;
                                r_bit_cnt <= 3'd0;
                                r_sda_t   <= 1'b1;
                            end else begin
                                // The fall that ends the ACK also presents
                                // the MSB of the first read byte.
                                r_state   <= ST_RD_BYTE;
                                r_bit_cnt <= 3'd0;
                                r_sda_t   <= r_regs[r_ptr][7];
                                r_tx      <= {r_regs[r_ptr][6:0], 1'b1};
                            end
                        end
                    end

                    ST_WR_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= ST_WR_ACK;
                                if (r_first) begin
                                    r_ptr   <= w_byte[3:0];
                                    r_first <= 1'b0;
                                end else begin
                                    r_regs[r_ptr] <= w_byte;
                                    r_ptr         <= r_ptr + 4'd1;
                                    r_wrote       <= 1'b1;
                                end
                            end
                        end
                    end

                    ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (r_sda_t) begin
                                r_sda_t <= 1'b0;
                            end else begin
                                r_sda_t   <= 1'b1;
                                r_state   <= ST_WR_BYTE;
                                r_bit_cnt <= 3'd0;
                            end
                        end
                    end

                    ST_RD_BYTE: begin
                        // MSB is already on the line at entry; each fall
                        // presents the next bit, the eighth fall releases.
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd7) begin
                                r_sda_t   <= 1'b1;
                                r_state   <= ST_RD_ACK;
                                r_bit_cnt <= 3'd0;
                                r_rd_more <= 1'b0;
                            end else begin
                                r_sda_t   <= r_tx[7];
                                r_tx      <= {r_tx[6:0], 1'b1};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                r_ptr     <= r_ptr + 4'd1;
                                r_rd_more <= 1'b1;
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end else if (w_scl_fall && r_rd_more) begin
                            // ptr was advanced on the ACK rise
                            r_state   <= ST_RD_BYTE;
                            r_rd_more <= 1'b0;
                            r_bit_cnt <= 3'd0;
                            r_sda_t   <= r_regs[r_ptr][7];
                            r_tx      <= {r_regs[r_ptr][6:0], 1'b1};
                        end
                    end

                    ST_IGNORE: begin
                        r_sda_t <= 1'b1;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        r_sda_t <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign sda_o = 1'b0;
    assign sda_t = r_sda_t;
    assign irq   = r_wr_done;

    //--------------------------------------------------------------------------
    // ctrl read path: one wait state, registered data and response.
    // A write in the same cycle as a read suppresses the read.
    //--------------------------------------------------------------------------
    logic       r_rd_ack;
    logic [7:0] r_readdata;
    logic [1:0] r_resp;
    logic       w_rd_wait;
    logic [7:0] w_rd_data;
    logic [1:0] w_rd_resp;

    assign w_rd_wait = ctrl.ctrl_read && !ctrl.ctrl_write && !r_rd_ack;

    always_comb begin
        w_rd_data = 8'h00;
        w_rd_resp = RESP_OKAY;
        if (ctrl.ctrl_address[7:4] == 4'h0) begin
            w_rd_data = r_regs[ctrl.ctrl_address[3:0]];
        end else if (ctrl.ctrl_address == REG_STATUS) begin
            w_rd_data = status_byte(r_ptr, w_busy, r_wr_done);
        end else begin
            w_rd_resp = RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ack   <= 1'b0;
            r_readdata <= 8'h00;
            r_resp     <= RESP_OKAY;
        end else begin
            r_rd_ack <= w_rd_wait;
            if (w_rd_wait) begin
                r_readdata <= w_rd_data;
                r_resp     <= w_rd_resp;
            end
        end
    end

    assign ctrl.ctrl_readdata    = {24'h000000, r_readdata};
    assign ctrl.ctrl_response    = r_resp;
    assign ctrl.ctrl_waitrequest = w_rd_wait;

    // Bits of the ctrl bus that carry no meaning for this block
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^{ctrl.ctrl_writedata[31:8], ctrl.ctrl_byteenable[3:1]};

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
//==============================================================================
// Module   : tb_i2c_target_regs
// Purpose  : Directed self-checking bench for i2c_target_regs. Acts as the
//            I2C controller (open-drain SDA model) and as the ctrl bus master.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_i2c_target_regs;

    localparam int Q = 10;   // clk cycles per SCL half period

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_o;
    logic sda_t;
    logic irq;
    logic sda_line;

    int n_tests = 0;
    int n_fail  = 0;

    logic watch = 1'b0;
    logic seen_low = 1'b0;

    i2c_target_regs_if bus ();

    // Open-drain bus: low if either side pulls it
    assign sda_line = sda_m & (sda_t | sda_o);

    i2c_target_regs #(.DEV_ADDR(7'h3C)) dut (
        .clk   (clk),
        .rst   (rst),
        .scl_i (scl_m),
        .sda_i (sda_line),
        .sda_o (sda_o),
        .sda_t (sda_t),
        .ctrl  (bus.slave),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (watch && !sda_t) seen_low = 1'b1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL clock: drive v while low, sample the line mid-high.
    // With collide set, a ctrl write 0x22 to regs[2] is issued so that it
    // lands on the same clk edge where the target commits this bit.
    task automatic i2c_bit(input logic v, input bit collide, output logic s);
        sda_m = v;
        wait_q(Q);
        scl_m = 1'b1;
        s = 1'b1;
        for (int k = 0; k < Q; k++) begin
            @(negedge clk);
            if (k == Q / 2) s = sda_line;
            if (collide && k == 1) begin
                bus.ctrl_address    = 8'h02;
                bus.ctrl_writedata  = 32'h22;
                bus.ctrl_byteenable = 4'h1;
                bus.ctrl_write      = 1'b1;
            end
            if (collide && k == 2) bus.ctrl_write = 1'b0;
        end
        scl_m = 1'b0;
        wait_q(2);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_q(Q);
        scl_m = 1'b1;
        wait_q(Q);
        sda_m = 1'b0;
        wait_q(Q);
        scl_m = 1'b0;
        wait_q(2);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_q(Q);
        scl_m = 1'b1;
        wait_q(Q);
        sda_m = 1'b1;
        wait_q(Q);
    endtask

    task automatic i2c_wr(input logic [7:0] b, input bit collide, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], collide && (i == 0), s);
        i2c_bit(1'b1, 1'b0, ack);
    endtask

    task automatic i2c_rd(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, 1'b0, s);
            b[i] = s;
        end
        i2c_bit(nack, 1'b0, s);
    endtask

    task automatic ctrl_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.ctrl_address    = a;
        bus.ctrl_writedata  = {24'h0, d};
        bus.ctrl_byteenable = 4'h1;
        bus.ctrl_write      = 1'b1;
        @(negedge clk);
        bus.ctrl_write      = 1'b0;
    endtask

    // ctrl read, checking the single wait state and the returned data/response
    task automatic rd_chk(input string tag, input logic [7:0] a,
                          input logic [7:0] exp_d, input logic [1:0] exp_r);
        bit got;
        int lat;
        logic [31:0] d;
        logic [1:0]  r;
        got = 1'b0;
        lat = -1;
        d   = '0;
        r   = '0;
        @(negedge clk);
        bus.ctrl_address = a;
        bus.ctrl_read    = 1'b1;
        #1;
        check_val({tag, "_wait"}, {31'h0, bus.ctrl_waitrequest}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!got && !bus.ctrl_waitrequest) begin
                got = 1'b1;
                lat = k;
                d   = bus.ctrl_readdata;
                r   = bus.ctrl_response;
            end
        end
        bus.ctrl_read = 1'b0;
        check_val({tag, "_lat"}, lat, 0);
        check_val({tag, "_data"}, d, {24'h0, exp_d});
        check_val({tag, "_resp"}, {30'h0, r}, {30'h0, exp_r});
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;

        bus.ctrl_address    = 8'h00;
        bus.ctrl_read       = 1'b0;
        bus.ctrl_write      = 1'b0;
        bus.ctrl_writedata  = 32'h0;
        bus.ctrl_byteenable = 4'h0;

        // Reset state
        wait_q(4);
        check_val("rst_sda_t", {31'h0, sda_t}, 32'h1);
        check_val("rst_sda_o", {31'h0, sda_o}, 32'h0);
        check_val("rst_irq", {31'h0, irq}, 32'h0);
        check_val("rst_wait", {31'h0, bus.ctrl_waitrequest}, 32'h0);
        check_val("rst_rdata", bus.ctrl_readdata, 32'h0);
        check_val("rst_resp", {30'h0, bus.ctrl_response}, 32'h0);
        rst = 1'b0;
        wait_q(4);
        rd_chk("rst_status", 8'h10, 8'h00, 2'b00);

        // 1: write 0xA1, 0xB2 starting at regs[5]
        i2c_start();
        i2c_wr(8'h78, 1'b0, ack); check_val("t1_addr_ack", {31'h0, ack}, 32'h0);
        i2c_wr(8'h05, 1'b0, ack); check_val("t1_ptr_ack", {31'h0, ack}, 32'h0);
        i2c_wr(8'hA1, 1'b0, ack); check_val("t1_d0_ack", {31'h0, ack}, 32'h0);
        i2c_wr(8'hB2, 1'b0, ack); check_val("t1_d1_ack", {31'h0, ack}, 32'h0);
        i2c_stop();
        check_val("t1_irq", {31'h0, irq}, 32'h1);
        rd_chk("t1_reg5", 8'h05, 8'hA1, 2'b00);
        rd_chk("t1_reg6", 8'h06, 8'hB2, 2'b00);
        rd_chk("t1_status", 8'h10, 8'h71, 2'b00);

        // 2: ctrl preload, then read back across the pointer wrap
        ctrl_wr(8'h0F, 8'h5A);
        ctrl_wr(8'h00, 8'hC3);
        i2c_start();
        i2c_wr(8'h78, 1'b0, ack); check_val("t2_addr_ack", {31'h0, ack}, 32'h0);
        rd_chk("t2_busy", 8'h10, 8'h73, 2'b00);
        i2c_wr(8'h0F, 1'b0, ack); check_val("t2_ptr_ack", {31'h0, ack}, 32'h0);
        i2c_start();
        i2c_wr(8'h79, 1'b0, ack); check_val("t2_raddr_ack", {31'h0, ack}, 32'h0);
        i2c_rd(1'b0, rb); check_val("t2_rd0", {24'h0, rb}, 32'h5A);
        i2c_rd(1'b1, rb); check_val("t2_rd1", {24'h0, rb}, 32'hC3);
        i2c_stop();
        rd_chk("t2_status", 8'h10, 8'h01, 2'b00);

        // 3: clear wr_done, then a transaction to a foreign address
        ctrl_wr(8'h10, 8'h01);
        check_val("t3_irq_clr", {31'h0, irq}, 32'h0);
        seen_low = 1'b0;
        watch    = 1'b1;
        i2c_start();
        i2c_wr(8'h7A, 1'b0, ack); check_val("t3_addr_nack", {31'h0, ack}, 32'h1);
        i2c_wr(8'h01, 1'b0, ack); check_val("t3_b0_nack", {31'h0, ack}, 32'h1);
        i2c_wr(8'hFF, 1'b0, ack); check_val("t3_b1_nack", {31'h0, ack}, 32'h1);
        i2c_stop();
        watch = 1'b0;
        check_val("t3_no_drive", {31'h0, seen_low}, 32'h0);
        check_val("t3_irq", {31'h0, irq}, 32'h0);
        rd_chk("t3_reg1", 8'h01, 8'h00, 2'b00);

        // 4: pointer-only write, then a data write and a wr_done clear
        i2c_start();
        i2c_wr(8'h78, 1'b0, ack);
        i2c_wr(8'h08, 1'b0, ack); check_val("t4_ptr_ack", {31'h0, ack}, 32'h0);
        i2c_stop();
        rd_chk("t4_status_ptr", 8'h10, 8'h80, 2'b00);
        check_val("t4_irq", {31'h0, irq}, 32'h0);
        i2c_start();
        i2c_wr(8'h78, 1'b0, ack);
        i2c_wr(8'h08, 1'b0, ack);
        i2c_wr(8'h33, 1'b0, ack);
        i2c_stop();
        rd_chk("t4_status_wr", 8'h10, 8'h91, 2'b00);
        ctrl_wr(8'h10, 8'h01);
        rd_chk("t4_status_clr", 8'h10, 8'h90, 2'b00);
        check_val("t4_irq_clr", {31'h0, irq}, 32'h0);

        // 5: out-of-range ctrl address
        rd_chk("t5_slverr", 8'h11, 8'h00, 2'b10);

        // 6: reset during bit 4 of a read of regs[0] = 0xC3
        i2c_start();
        i2c_wr(8'h78, 1'b0, ack);
        i2c_wr(8'h00, 1'b0, ack);
        i2c_start();
        i2c_wr(8'h79, 1'b0, ack);
        for (int i = 0; i < 3; i++) begin
            logic s;
            i2c_bit(1'b1, 1'b0, s);
        end
        wait_q(4);
        check_val("t6_bit4_drive", {31'h0, sda_t}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_sda_t", {31'h0, sda_t}, 32'h1);
        rst = 1'b0;
        wait_q(4);
        rd_chk("t6_status", 8'h10, 8'h00, 2'b00);
        i2c_start();
        i2c_wr(8'h78, 1'b0, ack); check_val("t6_addr_ack", {31'h0, ack}, 32'h0);
        i2c_wr(8'h03, 1'b0, ack); check_val("t6_ptr_ack", {31'h0, ack}, 32'h0);
        i2c_wr(8'h5C, 1'b0, ack); check_val("t6_d_ack", {31'h0, ack}, 32'h0);
        i2c_stop();
        rd_chk("t6_reg3", 8'h03, 8'h5C, 2'b00);
        rd_chk("t6_status2", 8'h10, 8'h41, 2'b00);

        // 7: I2C write and ctrl write hit regs[2] on the same edge
        i2c_start();
        i2c_wr(8'h78, 1'b0, ack);
        i2c_wr(8'h02, 1'b0, ack);
        i2c_wr(8'h11, 1'b1, ack); check_val("t7_d_ack", {31'h0, ack}, 32'h0);
        i2c_stop();
        rd_chk("t7_reg2", 8'h02, 8'h11, 2'b00);
        rd_chk("t7_status", 8'h10, 8'h31, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
